ddr_rd_sched: RTL and testbench
===============================

Name: ddr_rd_sched

Overview:
- N-port DDR read-request scheduler; successor to the fixed two-port read controller.
- Each uplink port pushes read requests (local queue id + byte count) into its own request FIFO.
- A round-robin arbiter grants one request at a time to the shared DDR read engine. Requests larger than P_MAX_CHUNK are split into chunk commands, and each chunk is acknowledged by a finish pulse.
- Sits between the per-port send logic and the DDR read AXI master.

Parameters:
- P_PORT_NUM, 2, number of uplink ports (2..8).
- C_M_AXI_ADDR_WIDTH, 32, width of byte-count fields.
- P_DDR_LOCAL_QUEUE, 3, width of the local queue id.
- P_REQ_FIFO_DEPTH, 4, entries per port request FIFO; power of two, at least 2.
- P_MAX_CHUNK, 4096, maximum bytes per issued chunk command; nonzero.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req_valid  in  P_PORT_NUM  per-port request valid
- o_req_ready  out  P_PORT_NUM  per-port ready; bit = FIFO not full
- i_req_queue  in  P_PORT_NUM*P_DDR_LOCAL_QUEUE  packed queue ids; port k at slice k
- i_req_byte  in  P_PORT_NUM*C_M_AXI_ADDR_WIDTH  packed byte counts
- o_zero_drop  out  P_PORT_NUM  1-cycle pulse when a zero-byte request is accepted and discarded
- o_rd_valid  out  1  chunk command valid
- i_rd_ready  in  1  engine accepts the command
- o_rd_port  out  clog2(P_PORT_NUM) (min 1)  granted port
- o_rd_queue  out  P_DDR_LOCAL_QUEUE  queue id of the command
- o_rd_byte  out  C_M_AXI_ADDR_WIDTH  chunk byte count
- o_rd_last  out  1  command is the final chunk of its request
- i_rd_finish  in  1  engine finished the current chunk (1-cycle pulse)
- o_port_pending  out  P_PORT_NUM  bit = port FIFO non-empty
- o_busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0, except o_req_ready all 1. FIFOs are empty, the round-robin pointer is 0, and the FSM is in IDLE. Reset asserted mid-operation aborts any in-flight chunk immediately and drops it; no finish is expected afterwards.
- Ingress, port k:
  - Handshake when i_req_valid[k] & o_req_ready[k].
  - byte==0: the request is not written; o_zero_drop[k] pulses on the next cycle.
  - Full FIFO: ready is low. No bypass, even if the FIFO pops in the same cycle.
- FSM states IDLE, ISSUE, WAIT_FIN:
  - IDLE: if any o_port_pending bit is set, pick the first pending port at or after rr_ptr (wrapping). Latch port, queue, and remaining = head byte count. Go to ISSUE. o_rd_valid rises on the next cycle.
  - Latency: a request accepted at cycle t into an empty system with an idle FSM gives o_rd_valid at t+2.
  - ISSUE: o_rd_valid=1, o_rd_byte = min(remaining, P_MAX_CHUNK), o_rd_last = (remaining <= P_MAX_CHUNK). All command fields stay stable until i_rd_ready. On handshake: remaining -= chunk, go to WAIT_FIN. o_rd_valid drops on the next cycle.
  - WAIT_FIN: wait for i_rd_finish.
    - If remaining != 0: go to ISSUE (next chunk, same port, no re-arbitration).
    - Else: pop the granted FIFO head, set rr_ptr = granted port + 1 (mod P_PORT_NUM), go to IDLE.
  - i_rd_finish in IDLE or ISSUE is ignored.
- A request is never interleaved with another port's chunks.
- The popped FIFO head is read-stable while granted, so new pushes to that port never disturb the latched request.
- Arithmetic: chunk compare and subtract are done at C_M_AXI_ADDR_WIDTH, unsigned. Requests that are exact multiples of P_MAX_CHUNK end with a full-size chunk with o_rd_last=1, never a zero chunk.
- o_port_pending and o_req_ready are registered from the FIFO counts. A pop and a push in the same cycle on the same FIFO keep the count unchanged.
- Fairness: with all ports continuously pending, grants rotate 0,1,…,N-1,0.

Decomposition:
- Package ddr_rd_pkg holds:
  - FSM state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT_FIN=2'd2.
  - A clog2 constant function.
  - Localparam for the port-index width.
- Sub-module ddr_req_fifo: synchronous FIFO, width P_DDR_LOCAL_QUEUE+C_M_AXI_ADDR_WIDTH, depth P_REQ_FIFO_DEPTH, async active-low reset, full/empty/count outputs. Instantiated per port via generate.
- The arbiter and FSM stay in the top.

Test Plan:
- Single request: port 1, queue 5, 1000 bytes, i_rd_ready tied 1.
  - Expect at t+2 one command: port=1, queue=5, byte=1000, last=1.
  - Finish 3 cycles later → o_busy=0 the next cycle; pending clears.
- Chunking: 10000 bytes, P_MAX_CHUNK=4096.
  - Expect chunks 4096, 4096, 1808; last=1 only on the third.
  - Each chunk is issued only after the prior finish.
  - 8192 bytes gives 4096, 4096 with last on the second.
- Round robin: P_PORT_NUM=4, all ports loaded with 2 requests of 64 bytes.
  - Expect grant order 0,1,2,3,0,1,2,3.
  - Then, with port 2 alone refilled, it is served next even though rr_ptr=0.
- Backpressure and full: push 5 requests to port 0 while the FSM is stalled (i_rd_ready=0).
  - Ready drops after 4; the 5th waits.
  - Command fields stay stable throughout the i_rd_ready=0 stall.
- Zero and spurious events: a 0-byte request on port 3 → o_zero_drop[3] pulse, no command. i_rd_finish pulsed in IDLE and ISSUE → no state change.
- Async reset in WAIT_FIN with 2 chunks remaining: all outputs return to reset values without a clock edge. After release, FIFOs are empty and no command issues.

Source files
------------

// File: rtl/ddr_rd_pkg.sv
// ---------------------------------------------------------------------------
// ddr_rd_pkg
// Shared definitions for the DDR read-request scheduler:
//   - scheduler FSM state encoding (IDLE / ISSUE / WAIT_FIN)
//   - clog2 / idx_width constant functions for sizing index and count fields
//   - port-index width for the largest supported port count
// ---------------------------------------------------------------------------
package ddr_rd_pkg;

  // Scheduler FSM encoding. It is kept as plain 2-bit constants so the
  // encoding stays compatible with the older two-port controller.
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE    = 2'd1;
  localparam logic [1:0] WAIT_FIN = 2'd2;

  // Ceiling log2. Returns 0 for values of 0 and 1.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      res++;
    end
    return res;
  endfunction

  // Width of an index into n items. It is never narrower than one bit, so a
  // single-item index still has a legal vector range.
  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  localparam int PORT_NUM_MAX   = 8;
  localparam int PORT_IDX_W_MAX = idx_width(PORT_NUM_MAX);

endpackage

// File: rtl/ddr_req_fifo.sv
// ---------------------------------------------------------------------------
// ddr_req_fifo
// Per-port synchronous request FIFO. Each entry holds {queue id, byte count}.
// The head entry is presented combinationally and does not change until it
// is popped. Writes always land in a different slot, so the head stays
// stable while the scheduler owns it.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_push, i_data  write one entry. The write is ignored when the FIFO is full.
//   i_pop           discard the head entry. The pop is ignored when the FIFO is empty.
//   o_head          current head entry
//   o_full/o_empty  occupancy flags, derived from the registered count
//   o_count         registered number of stored entries (0..P_DEPTH)
// ---------------------------------------------------------------------------
module ddr_req_fifo
  import ddr_rd_pkg::*;
#(
  parameter int P_WIDTH = 35,
  parameter int P_DEPTH = 4     // power of two, at least 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_push,
  input  logic [P_WIDTH-1:0]        i_data,
  input  logic                      i_pop,
  output logic [P_WIDTH-1:0]        o_head,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [clog2(P_DEPTH):0]   o_count
);

  localparam int                PTR_W    = clog2(P_DEPTH);
  localparam logic [PTR_W:0]    CNT_FULL = (PTR_W + 1)'(P_DEPTH);

  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               do_push;
  logic               do_pop;

  assign do_push = i_push && (count != CNT_FULL);
  assign do_pop  = i_pop  && (count != '0);

  // NOTE: storage has no reset. The count and pointers define which entries
  // are valid, and leaving the array out of reset lets it map onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // NOTE: all state uses non-blocking assignments, so every register samples
  // values from before the edge. This avoids ordering races between blocks.
  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // A push and a pop in the same cycle leave the count unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign o_head  = mem[rd_ptr];
  assign o_full  = (count == CNT_FULL);
  assign o_empty = (count == '0);
  assign o_count = count;

endmodule

// File: rtl/ddr_rd_sched.sv
// ---------------------------------------------------------------------------
// ddr_rd_sched
// N-port DDR read-request scheduler. Each uplink port queues requests of the
// form {queue id, byte count} in its own FIFO. A round-robin arbiter hands one
// request at a time to the shared DDR read engine. Requests larger than
// P_MAX_CHUNK are issued as successive chunk commands. Each chunk must be
// acknowledged by i_rd_finish before the next chunk is issued. A request is
// never interleaved with chunks from another port.
//
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_req_valid       per-port request valid
//   o_req_ready       per-port ready (FIFO not full)
//   i_req_queue       packed per-port queue ids (port k at slice k)
//   i_req_byte        packed per-port byte counts
//   o_zero_drop       per-port pulse, one cycle after a zero-byte request is
//                     accepted and discarded
//   o_rd_valid        chunk command valid
//   i_rd_ready        engine accepts the command
//   o_rd_port         granted port
//   o_rd_queue        queue id of the command
//   o_rd_byte         chunk byte count
//   o_rd_last         command is the final chunk of its request
//   i_rd_finish       engine finished the current chunk (1-cycle pulse)
//   o_port_pending    per-port FIFO non-empty
//   o_busy            scheduler FSM not idle
// ---------------------------------------------------------------------------
module ddr_rd_sched
  import ddr_rd_pkg::*;
#(
  parameter int P_PORT_NUM         = 2,     // 2..8
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int P_DDR_LOCAL_QUEUE  = 3,
  parameter int P_REQ_FIFO_DEPTH   = 4,     // power of two, at least 2
  parameter int P_MAX_CHUNK        = 4096   // nonzero
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst_n,
  input  logic [P_PORT_NUM-1:0]                      i_req_valid,
  output logic [P_PORT_NUM-1:0]                      o_req_ready,
  input  logic [P_PORT_NUM*P_DDR_LOCAL_QUEUE-1:0]    i_req_queue,
  input  logic [P_PORT_NUM*C_M_AXI_ADDR_WIDTH-1:0]   i_req_byte,
  output logic [P_PORT_NUM-1:0]                      o_zero_drop,
  output logic                                       o_rd_valid,
  input  logic                                       i_rd_ready,
  output logic [idx_width(P_PORT_NUM)-1:0]           o_rd_port,
  output logic [P_DDR_LOCAL_QUEUE-1:0]               o_rd_queue,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]              o_rd_byte,
  output logic                                       o_rd_last,
  input  logic                                       i_rd_finish,
  output logic [P_PORT_NUM-1:0]                      o_port_pending,
  output logic                                       o_busy
);

  localparam int PORT_W = idx_width(P_PORT_NUM);
  localparam int AW     = C_M_AXI_ADDR_WIDTH;
  localparam int QW     = P_DDR_LOCAL_QUEUE;
  localparam int EW     = QW + AW;
  localparam int CNT_W  = clog2(P_REQ_FIFO_DEPTH) + 1;

  localparam logic [AW-1:0]     MAX_CHUNK = AW'(P_MAX_CHUNK);
  localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(P_PORT_NUM - 1);

  // -------------------------------------------------------------------------
  // Per-port ingress and request FIFOs
  // -------------------------------------------------------------------------
  logic [P_PORT_NUM-1:0] accept;
  logic [P_PORT_NUM-1:0] push;
  logic [P_PORT_NUM-1:0] drop;
  logic [P_PORT_NUM-1:0] pop;
  logic [P_PORT_NUM-1:0] fifo_full;
  logic [P_PORT_NUM-1:0] fifo_empty;
  logic [CNT_W-1:0]      fifo_count [P_PORT_NUM];
  logic [EW-1:0]         fifo_head  [P_PORT_NUM];
  logic [QW-1:0]         head_queue [P_PORT_NUM];
  logic [AW-1:0]         head_byte  [P_PORT_NUM];

  logic [1:0]            state;
  logic [PORT_W-1:0]     rr_ptr;
  logic [AW-1:0]         remaining;
  logic                  fin_done;

  // The last chunk of the granted request has been acknowledged. This is
  // the only point at which a FIFO head is released.
  assign fin_done = (state == WAIT_FIN) && i_rd_finish && (remaining == '0);

  for (genvar k = 0; k < P_PORT_NUM; k++) begin : g_port
    logic [QW-1:0] in_queue;
    logic [AW-1:0] in_byte;

    assign in_queue = i_req_queue[k*QW +: QW];
    assign in_byte  = i_req_byte[k*AW +: AW];

    // Ready comes only from the registered occupancy. A pop in the same
    // cycle never opens a slot early, so there is no bypass path.
    assign accept[k] = i_req_valid[k] && !fifo_full[k];
    assign push[k]   = accept[k] && (in_byte != '0);
    assign drop[k]   = accept[k] && (in_byte == '0);
    assign pop[k]    = fin_done && (o_rd_port == PORT_W'(k)) && !fifo_empty[k];

    ddr_req_fifo #(
      .P_WIDTH (EW),
      .P_DEPTH (P_REQ_FIFO_DEPTH)
    ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (push[k]),
      .i_data  ({in_queue, in_byte}),
      .i_pop   (pop[k]),
      .o_head  (fifo_head[k]),
      .o_full  (fifo_full[k]),
      .o_empty (fifo_empty[k]),
      .o_count (fifo_count[k])
    );

    assign head_queue[k]     = fifo_head[k][EW-1:AW];
    assign head_byte[k]      = fifo_head[k][AW-1:0];
    assign o_req_ready[k]    = !fifo_full[k];
    assign o_port_pending[k] = (fifo_count[k] != '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_zero_drop <= '0;
    end else begin
      o_zero_drop <= drop;
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin arbiter: first pending port at or after rr_ptr, with wrap
  // -------------------------------------------------------------------------
  logic              arb_found;
  logic [PORT_W-1:0] arb_port;
  int                arb_idx;

  // NOTE: every signal assigned in an always_comb block gets a default value
  // first. Without the default, a missed branch would infer a latch.
  always_comb begin
    arb_found = 1'b0;
    arb_port  = '0;
    arb_idx   = 0;
    for (int i = 0; i < P_PORT_NUM; i++) begin
      arb_idx = (int'(rr_ptr) + i) % P_PORT_NUM;
      if (!arb_found && o_port_pending[arb_idx]) begin
        arb_found = 1'b1;
        arb_port  = PORT_W'(arb_idx);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Chunking FSM
  // -------------------------------------------------------------------------
  logic [AW-1:0] chunk;
  logic          chunk_last;

  // Exact multiples of P_MAX_CHUNK end on a full-size chunk marked last.
  // The remainder therefore reaches zero without issuing a zero-length
  // command.
  assign chunk      = (remaining > MAX_CHUNK) ? MAX_CHUNK : remaining;
  assign chunk_last = (remaining <= MAX_CHUNK);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      remaining  <= '0;
      o_rd_port  <= '0;
      o_rd_queue <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            o_rd_port  <= arb_port;
            o_rd_queue <= head_queue[arb_port];
            remaining  <= head_byte[arb_port];
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_rd_ready) begin
            remaining <= remaining - chunk;
            state     <= WAIT_FIN;
          end
        end
        WAIT_FIN: begin
          if (i_rd_finish) begin
            if (remaining != '0) begin
              // Same port continues with no re-arbitration between chunks.
              state <= ISSUE;
            end else begin
              rr_ptr <= (o_rd_port == LAST_PORT) ? '0 : o_rd_port + 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Command byte and last flags are qualified by ISSUE. They therefore read
  // zero whenever no command is being offered, including right after reset.
  assign o_rd_valid = (state == ISSUE);
  assign o_rd_byte  = o_rd_valid ? chunk : '0;
  assign o_rd_last  = o_rd_valid && chunk_last;
  assign o_busy     = (state != IDLE);

endmodule

// File: tb/tb_ddr_rd_sched.sv
// ---------------------------------------------------------------------------
// tb_ddr_rd_sched
// Self-checking bench for ddr_rd_sched with four ports. Expected chunk
// commands are pushed to a scoreboard queue when requests are accepted. They
// are popped and compared whenever the DUT hands a command to the modelled
// read engine. The engine pulses finish three cycles after each accepted
// command.
// ---------------------------------------------------------------------------
module tb_ddr_rd_sched;

  localparam int N     = 4;
  localparam int AW    = 32;
  localparam int QW    = 3;
  localparam int DEPTH = 4;
  localparam int MAXC  = 4096;
  localparam int PW    = 2;

  typedef struct packed {
    logic [PW-1:0] port;
    logic [QW-1:0] queue;
    logic [AW-1:0] nbytes;
    logic          last;
  } cmd_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*QW-1:0] req_queue = '0;
  logic [N*AW-1:0] req_byte = '0;
  logic [N-1:0]    zero_drop;
  logic            rd_valid;
  logic            rd_ready = 1'b1;
  logic [PW-1:0]   rd_port;
  logic [QW-1:0]   rd_queue;
  logic [AW-1:0]   rd_byte;
  logic            rd_last;
  logic            rd_finish;
  logic            eng_fin = 1'b0;
  logic            man_fin = 1'b0;
  logic [N-1:0]    pending;
  logic            busy;

  assign rd_finish = eng_fin | man_fin;

  always #5 clk = ~clk;

  ddr_rd_sched #(
    .P_PORT_NUM         (N),
    .C_M_AXI_ADDR_WIDTH (AW),
    .P_DDR_LOCAL_QUEUE  (QW),
    .P_REQ_FIFO_DEPTH   (DEPTH),
    .P_MAX_CHUNK        (MAXC)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_queue    (req_queue),
    .i_req_byte     (req_byte),
    .o_zero_drop    (zero_drop),
    .o_rd_valid     (rd_valid),
    .i_rd_ready     (rd_ready),
    .o_rd_port      (rd_port),
    .o_rd_queue     (rd_queue),
    .o_rd_byte      (rd_byte),
    .o_rd_last      (rd_last),
    .i_rd_finish    (rd_finish),
    .o_port_pending (pending),
    .o_busy         (busy)
  );

  cmd_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   auto_fin = 1'b1;
  bit   outstanding = 1'b0;
  int   fin_cnt = 0;

  // One clock cycle. The command monitor samples at the falling edge, and
  // the engine model updates finish just after the rising edge.
  task automatic step();
    cmd_t got;
    cmd_t exp;
    @(negedge clk);
    if (rst_n) begin
      if (rd_finish) outstanding = 1'b0;
      if (rd_valid && rd_ready) begin
        got = {rd_port, rd_queue, rd_byte, rd_last};
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL cmd_unexpected: got port=%0d queue=%0d bytes=%0d last=%0d, required no command",
                   rd_port, rd_queue, rd_byte, rd_last);
        end else begin
          exp = sb.pop_front();
          if (got !== exp || outstanding) begin
            $display("FAIL cmd: got port=%0d queue=%0d bytes=%0d last=%0d overlap=%0d, required port=%0d queue=%0d bytes=%0d last=%0d overlap=0",
                     rd_port, rd_queue, rd_byte, rd_last, outstanding,
                     exp.port, exp.queue, exp.nbytes, exp.last);
          end else begin
            n_pass++;
          end
        end
        outstanding = 1'b1;
        if (auto_fin) fin_cnt = 3;
      end
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      fin_cnt = 0;
      eng_fin = 1'b0;
      outstanding = 1'b0;
    end else if (fin_cnt > 0) begin
      fin_cnt--;
      eng_fin = (fin_cnt == 0);
    end else begin
      eng_fin = 1'b0;
    end
  endtask

  task automatic set_req(input int p, input logic [QW-1:0] q, input logic [AW-1:0] b, input bit v);
    req_valid[p]          = v;
    req_queue[p*QW +: QW] = q;
    req_byte[p*AW +: AW]  = b;
  endtask

  // Reference chunking model: split a request into commands of at most MAXC.
  task automatic model_push(input int p, input logic [QW-1:0] q, input logic [AW-1:0] b);
    logic [AW-1:0] rem;
    logic [AW-1:0] c;
    rem = b;
    while (rem != 0) begin
      c = (rem > MAXC) ? AW'(MAXC) : rem;
      sb.push_back({PW'(p), q, c, (rem <= MAXC)});
      rem = rem - c;
    end
  endtask

  task automatic push_one(input int p, input logic [QW-1:0] q, input logic [AW-1:0] b, input bit model);
    bit ok;
    ok = 1'b0;
    set_req(p, q, b, 1'b1);
    for (int i = 0; i < 64; i++) begin
      if (req_ready[p]) begin
        ok = 1'b1;
        if (model) model_push(p, q, b);
        step();
        break;
      end
      step();
    end
    set_req(p, '0, '0, 1'b0);
    if (!ok) begin
      n_checks++;
      $display("FAIL push_timeout: port %0d ready stayed 0, required acceptance", p);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (!busy && pending == '0 && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) $display("FAIL %s_idle: busy=%0d pending=%b sb_left=%0d, required 0/0000/0",
                      name, busy, pending, sb.size());
    else n_pass++;
  endtask

  task automatic apply_reset();
    req_valid = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    for (int pass = 0; pass < 2; pass++) begin
      n_checks++;
      if (req_ready !== 4'hF) $display("FAIL reset_ready: got %b, required 1111", req_ready);
      else n_pass++;
      n_checks++;
      if ({rd_valid, busy, pending, zero_drop} !== 10'b0)
        $display("FAIL reset_status: valid=%0d busy=%0d pending=%b zero_drop=%b, required all 0",
                 rd_valid, busy, pending, zero_drop);
      else n_pass++;
      n_checks++;
      if ({rd_port, rd_queue, rd_byte, rd_last} !== '0)
        $display("FAIL reset_cmd: port=%0d queue=%0d bytes=%0d last=%0d, required all 0",
                 rd_port, rd_queue, rd_byte, rd_last);
      else n_pass++;
      rst_n = 1'b1;
      step();
    end
  endtask

  task automatic test_single();
    bit seen;
    rd_ready = 1'b1;
    set_req(1, 3'd5, 32'd1000, 1'b1);
    n_checks++;
    if (req_ready[1] !== 1'b1) $display("FAIL single_ready: got %0d, required 1", req_ready[1]);
    else n_pass++;
    model_push(1, 3'd5, 32'd1000);
    step();
    set_req(1, '0, '0, 1'b0);
    n_checks++;
    if (rd_valid !== 1'b0) $display("FAIL single_lat_t1: valid=%0d, required 0", rd_valid);
    else n_pass++;
    step();
    n_checks++;
    if (rd_valid !== 1'b1) $display("FAIL single_lat_t2: valid=%0d, required 1", rd_valid);
    else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rd_finish) begin
        seen = 1'b1;
        break;
      end
    end
    step();
    n_checks++;
    if (!seen || busy !== 1'b0 || pending !== 4'b0)
      $display("FAIL single_done: finish_seen=%0d busy=%0d pending=%b, required 1/0/0000", seen, busy, pending);
    else n_pass++;
    n_checks++;
    if (sb.size() != 0) $display("FAIL single_sb: %0d commands missing, required 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_chunking();
    rd_ready = 1'b1;
    push_one(0, 3'd2, 32'd10000, 1'b1);
    wait_idle("chunk_10000");
    push_one(0, 3'd3, 32'd8192, 1'b1);
    wait_idle("chunk_8192");
  endtask

  task automatic test_round_robin();
    apply_reset();
    rd_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < N; k++) begin
        set_req(k, QW'(k * 2 + j), 32'd64, 1'b1);
      end
      n_checks++;
      if (req_ready !== 4'hF) $display("FAIL rr_load_ready: got %b, required 1111", req_ready);
      else n_pass++;
      step();
    end
    req_valid = '0;
    // With every port pending from the start, grants rotate 0,1,2,3,0,1,2,3.
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < N; k++) begin
        sb.push_back({PW'(k), QW'(k * 2 + j), 32'd64, 1'b1});
      end
    end
    wait_idle("rr_rotate");
    // The pointer is back at 0, and port 2 alone is pending.
    push_one(2, 3'd1, 32'd64, 1'b1);
    wait_idle("rr_single_port2");
  endtask

  task automatic test_backpressure();
    cmd_t held;
    bit   ok;
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(0, QW'(i + 1), AW'(100 * (i + 1)), 1'b1);
      n_checks++;
      if (req_ready[0] !== 1'b1) $display("FAIL bp_ready_%0d: got 0, required 1", i);
      else n_pass++;
      model_push(0, QW'(i + 1), AW'(100 * (i + 1)));
      step();
    end
    set_req(0, 3'd5, 32'd500, 1'b1);
    held = {2'd0, 3'd1, 32'd100, 1'b1};
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (req_ready[0] !== 1'b0) $display("FAIL bp_full_%0d: ready=1, required 0", i);
      else n_pass++;
      n_checks++;
      if (rd_valid !== 1'b1 || {rd_port, rd_queue, rd_byte, rd_last} !== held)
        $display("FAIL bp_stall_%0d: valid=%0d port=%0d queue=%0d bytes=%0d last=%0d, required 1/0/1/100/1",
                 i, rd_valid, rd_port, rd_queue, rd_byte, rd_last);
      else n_pass++;
      step();
    end
    rd_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (req_ready[0]) begin
        ok = 1'b1;
        model_push(0, 3'd5, 32'd500);
        step();
        break;
      end
      step();
    end
    set_req(0, '0, '0, 1'b0);
    n_checks++;
    if (!ok) $display("FAIL bp_fifth: never accepted, required acceptance after a pop");
    else n_pass++;
    wait_idle("bp_drain");
  endtask

  task automatic test_zero_spurious();
    bit quiet;
    rd_ready = 1'b1;
    set_req(3, 3'd4, 32'd0, 1'b1);
    step();
    set_req(3, '0, '0, 1'b0);
    n_checks++;
    if (zero_drop !== 4'b1000) $display("FAIL zero_pulse: got %b, required 1000", zero_drop);
    else n_pass++;
    step();
    n_checks++;
    if (zero_drop !== 4'b0000) $display("FAIL zero_pulse_end: got %b, required 0000", zero_drop);
    else n_pass++;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (rd_valid || busy || pending != 4'b0) quiet = 1'b0;
      step();
    end
    n_checks++;
    if (!quiet) $display("FAIL zero_no_cmd: activity seen, required none");
    else n_pass++;

    man_fin = 1'b1;
    step();
    man_fin = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0 || rd_valid !== 1'b0) $display("FAIL fin_in_idle: busy=%0d valid=%0d, required 0/0", busy, rd_valid);
    else n_pass++;

    rd_ready = 1'b0;
    push_one(1, 3'd6, 32'd500, 1'b1);
    step();
    n_checks++;
    if (rd_valid !== 1'b1) $display("FAIL issue_reach: valid=%0d, required 1", rd_valid);
    else n_pass++;
    man_fin = 1'b1;
    step();
    man_fin = 1'b0;
    step();
    n_checks++;
    if (rd_valid !== 1'b1 || busy !== 1'b1 || rd_byte !== 32'd500)
      $display("FAIL fin_in_issue: valid=%0d busy=%0d bytes=%0d, required 1/1/500", rd_valid, busy, rd_byte);
    else n_pass++;
    rd_ready = 1'b1;
    wait_idle("spurious_drain");
  endtask

  task automatic test_async_reset();
    bit quiet;
    bit hs;
    auto_fin = 1'b0;
    rd_ready = 1'b1;
    // 12288 bytes: after the first chunk, two chunks remain.
    push_one(2, 3'd3, 32'd12288, 1'b0);
    sb.push_back({2'd2, 3'd3, 32'd4096, 1'b0});
    push_one(0, 3'd7, 32'd100, 1'b0);
    hs = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (outstanding) begin
        hs = 1'b1;
        break;
      end
      step();
    end
    n_checks++;
    if (!hs || busy !== 1'b1 || rd_valid !== 1'b0 || pending !== 4'b0101)
      $display("FAIL ar_wait_fin: handshake=%0d busy=%0d valid=%0d pending=%b, required 1/1/0/0101",
               hs, busy, rd_valid, pending);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'hF || pending !== 4'b0 || busy !== 1'b0 || rd_valid !== 1'b0 ||
        {rd_port, rd_queue, rd_byte, rd_last} !== '0 || zero_drop !== 4'b0)
      $display("FAIL ar_immediate: ready=%b pending=%b busy=%0d valid=%0d port=%0d queue=%0d bytes=%0d, required reset values",
               req_ready, pending, busy, rd_valid, rd_port, rd_queue, rd_byte);
    else n_pass++;
    step();
    step();
    rst_n = 1'b1;
    auto_fin = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rd_valid || busy || pending != 4'b0 || req_ready != 4'hF) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) $display("FAIL ar_after_release: activity after reset, required idle and empty");
    else n_pass++;
    n_checks++;
    if (sb.size() != 0) $display("FAIL ar_sb: %0d commands missing, required 0", sb.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_chunking();
    test_round_robin();
    test_backpressure();
    test_zero_spurious();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
